// File: rtl/mux_2_response_checker.sv
// mux_2_response_checker: scores the response of a 2:1 mux DUT against a golden
// model over a programmed number of vectors, keeping pass/fail counts, the index
// of the first failing vector and a final verdict.
// Optional failure log: define MUX2_CHK_FAIL_LOG_EN to keep a first-word-fall-through
// FIFO of failing vectors {A,B,C,Y}; without it the log outputs are tied off.

module mux_2_response_checker #(
    parameter int unsigned ITERATIONS = 10,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned LOG_DEPTH  = 4
) (
    input  logic             In_Clk,
    input  logic             In_Rst_n,
    input  logic             In_Start,
    input  logic             In_Valid,
    input  logic             In_A,
    input  logic             In_B,
    input  logic             In_C,
    input  logic             In_Y,
    output logic             Out_Busy,
    output logic             Out_Done,
    output logic             Out_Pass,
    output logic             Out_Mismatch,
    output logic [CNT_W-1:0] Out_Pass_Cnt,
    output logic [CNT_W-1:0] Out_Fail_Cnt,
    output logic [CNT_W-1:0] Out_First_Fail_Idx,
    input  logic             In_Log_Rd,
    output logic [3:0]       Out_Log_Data,
    output logic             Out_Log_Empty,
    output logic             Out_Log_Ovf
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITERATIONS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] idx;

    // Golden model and per-sample decode
    logic expected_c;
    logic mismatch_c;
    logic consume_c;
    logic start_c;
    logic last_c;

    assign expected_c = In_C ? In_B : In_A;
    assign mismatch_c = (In_Y != expected_c);
    assign start_c    = In_Start && (state != RUN);
    assign consume_c  = In_Valid && (state == RUN);
    assign last_c     = (idx == LAST_IDX);

    // Run control FSM with registered results
    always_ff @(posedge In_Clk or negedge In_Rst_n) begin
        if (!In_Rst_n) begin
            state              <= IDLE;
            idx                <= '0;
            Out_Busy           <= 1'b0;
            Out_Done           <= 1'b0;
            Out_Pass           <= 1'b0;
            Out_Mismatch       <= 1'b0;
            Out_Pass_Cnt       <= '0;
            Out_Fail_Cnt       <= '0;
            Out_First_Fail_Idx <= '1;
        end else begin
            Out_Mismatch <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (In_Start) begin
                        state              <= RUN;
                        idx                <= '0;
                        Out_Busy           <= 1'b1;
                        Out_Done           <= 1'b0;
                        Out_Pass           <= 1'b0;
                        Out_Pass_Cnt       <= '0;
                        Out_Fail_Cnt       <= '0;
                        Out_First_Fail_Idx <= '1;
                    end
                end
                RUN: begin
                    if (In_Valid) begin
                        if (idx != CNT_MAX) begin
                            idx <= idx + CNT_W'(1);
                        end
                        if (mismatch_c) begin
                            Out_Mismatch <= 1'b1;
                            if (Out_Fail_Cnt != CNT_MAX) begin
                                Out_Fail_Cnt <= Out_Fail_Cnt + CNT_W'(1);
                            end
                            if (Out_Fail_Cnt == '0) begin
                                Out_First_Fail_Idx <= idx;
                            end
                        end else if (Out_Pass_Cnt != CNT_MAX) begin
                            Out_Pass_Cnt <= Out_Pass_Cnt + CNT_W'(1);
                        end
                        if (last_c) begin
                            state    <= DONE;
                            Out_Busy <= 1'b0;
                            Out_Done <= 1'b1;
                            Out_Pass <= (Out_Fail_Cnt == '0) && !mismatch_c;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    Out_Busy <= 1'b0;
                    Out_Done <= 1'b0;
                    Out_Pass <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX2_CHK_FAIL_LOG_EN

    localparam int unsigned AW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] LAST_SLOT = AW'(LOG_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(LOG_DEPTH);

    logic [3:0]    log_mem [LOG_DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [CW-1:0] log_cnt;

    logic log_empty_c;
    logic log_full_c;
    logic push_c;
    logic pop_c;
    logic push_ok_c;

    assign log_empty_c = (log_cnt == '0);
    assign log_full_c  = (log_cnt == FULL_CNT);
    assign push_c      = consume_c && mismatch_c;
    assign pop_c       = In_Log_Rd && !log_empty_c && !start_c;
    // A full log still accepts a push when the head is popped in the same cycle
    assign push_ok_c   = push_c && (!log_full_c || pop_c);

    // Log pointers, occupancy and sticky overflow
    always_ff @(posedge In_Clk or negedge In_Rst_n) begin
        if (!In_Rst_n) begin
            wr_idx      <= '0;
            rd_idx      <= '0;
            log_cnt     <= '0;
            Out_Log_Ovf <= 1'b0;
        end else if (start_c) begin
            wr_idx      <= '0;
            rd_idx      <= '0;
            log_cnt     <= '0;
            Out_Log_Ovf <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_idx <= (wr_idx == LAST_SLOT) ? '0 : wr_idx + AW'(1);
            end
            if (pop_c) begin
                rd_idx <= (rd_idx == LAST_SLOT) ? '0 : rd_idx + AW'(1);
            end
            if (push_ok_c && !pop_c) begin
                log_cnt <= log_cnt + CW'(1);
            end else if (pop_c && !push_ok_c) begin
                log_cnt <= log_cnt - CW'(1);
            end
            if (push_c && !push_ok_c) begin
                Out_Log_Ovf <= 1'b1;
            end
        end
    end

    // Log storage; contents are only observed through the occupancy-qualified head
    always_ff @(posedge In_Clk) begin
        if (push_ok_c) begin
            log_mem[wr_idx] <= {In_A, In_B, In_C, In_Y};
        end
    end

    assign Out_Log_Empty = log_empty_c;
    assign Out_Log_Data  = log_empty_c ? 4'b0000 : log_mem[rd_idx];

`else

    logic unused_log_rd;
    assign unused_log_rd = In_Log_Rd;

    // Log disabled: constant empty, no data, never overflows
    always_ff @(posedge In_Clk or negedge In_Rst_n) begin
        if (!In_Rst_n) begin
            Out_Log_Ovf <= 1'b0;
        end else begin
            Out_Log_Ovf <= 1'b0;
        end
    end

    assign Out_Log_Empty = 1'b1;
    assign Out_Log_Data  = 4'b0000;

`endif

endmodule

// File: tb/tb_mux_2_response_checker.sv
// Directed bench for mux_2_response_checker (ITERATIONS=10, CNT_W=8, LOG_DEPTH=4).

module tb_mux_2_response_checker;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, valid, a, b, c, y, log_rd;
    logic             busy, done, pass, mism, log_empty, log_ovf;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, ffi;
    logic [3:0]       log_data;

    int tests  = 0;
    int failed = 0;
    int pulses = 0;

    // {A,B,C} per sample and the hand-computed golden Y (C ? B : A)
    logic [2:0] vec    [10] = '{3'b001, 3'b011, 3'b011, 3'b011, 3'b010,
                                3'b101, 3'b110, 3'b010, 3'b000, 3'b010};
    logic       gold_y [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    mux_2_response_checker #(
        .ITERATIONS(10),
        .CNT_W     (CNT_W),
        .LOG_DEPTH (4)
    ) dut (
        .In_Clk            (clk),
        .In_Rst_n          (rst_n),
        .In_Start          (start),
        .In_Valid          (valid),
        .In_A              (a),
        .In_B              (b),
        .In_C              (c),
        .In_Y              (y),
        .Out_Busy          (busy),
        .Out_Done          (done),
        .Out_Pass          (pass),
        .Out_Mismatch      (mism),
        .Out_Pass_Cnt      (pass_cnt),
        .Out_Fail_Cnt      (fail_cnt),
        .Out_First_Fail_Idx(ffi),
        .In_Log_Rd         (log_rd),
        .Out_Log_Data      (log_data),
        .Out_Log_Empty     (log_empty),
        .Out_Log_Ovf       (log_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic send(input int i, input logic inv);
        {a, b, c} = vec[i];
        y         = gold_y[i] ^ inv;
        valid     = 1'b1;
        cyc();
        valid     = 1'b0;
        if (mism) pulses++;
    endtask

    task automatic pop_log();
        log_rd = 1'b1;
        cyc();
        log_rd = 1'b0;
    endtask

    task automatic run_seq(input logic [9:0] inv, input bit gapped);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            send(i, inv[i]);
            if (i == 8) chk("pre_last_busy", 32'(busy), 32'd1);
            if (gapped && i < 9) begin
                if (i == 4) start = 1'b1;
                cyc();
                start = 1'b0;
                if (i == 4) begin
                    chk("midstart_busy", 32'(busy), 32'd1);
                    chk("midstart_pass_cnt", 32'(pass_cnt), 32'd5);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {start, valid, a, b, c, y, log_rd} = '0;
        repeat (2) cyc();

        // Reset values
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_mism", 32'(mism), 32'd0);
        chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("rst_ffi", 32'(ffi), 32'hFF);
        chk("rst_log_empty", 32'(log_empty), 32'd1);
        chk("rst_log_data", 32'(log_data), 32'd0);
        chk("rst_log_ovf", 32'(log_ovf), 32'd0);
        rst_n = 1'b1;
        cyc();

        // All ten samples match
        start_run();
        run_seq(10'b0, 1'b0);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_pass_cnt", 32'(pass_cnt), 32'd10);
        chk("t1_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("t1_ffi", 32'(ffi), 32'hFF);
        chk("t1_pulses", 32'(pulses), 32'd0);

        // Valid while DONE is ignored
        {a, b, c} = 3'b000;
        y = 1'b1;
        valid = 1'b1;
        cyc();
        valid = 1'b0;
        chk("done_valid_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("done_valid_mism", 32'(mism), 32'd0);
        chk("done_valid_pass_cnt", 32'(pass_cnt), 32'd10);

        // Start with a coincident mismatching valid: sample not consumed
        start = 1'b1;
        valid = 1'b1;
        cyc();
        start = 1'b0;
        valid = 1'b0;
        chk("sv_busy", 32'(busy), 32'd1);
        chk("sv_done", 32'(done), 32'd0);
        chk("sv_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("sv_pass_cnt", 32'(pass_cnt), 32'd0);

        // Samples 3 and 7 inverted
        run_seq(10'b0010001000, 1'b0);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_pass", 32'(pass), 32'd0);
        chk("t2_fail_cnt", 32'(fail_cnt), 32'd2);
        chk("t2_pass_cnt", 32'(pass_cnt), 32'd8);
        chk("t2_ffi", 32'(ffi), 32'd3);
        chk("t2_pulses", 32'(pulses), 32'd2);
`ifdef MUX2_CHK_FAIL_LOG_EN
        chk("t2_log_empty0", 32'(log_empty), 32'd0);
        chk("t2_log_data0", 32'(log_data), 32'h6);
        pop_log();
        chk("t2_log_data1", 32'(log_data), 32'h5);
        pop_log();
        chk("t2_log_empty2", 32'(log_empty), 32'd1);
        chk("t2_log_data2", 32'(log_data), 32'h0);
        pop_log();
        chk("t2_log_empty3", 32'(log_empty), 32'd1);
        chk("t2_log_ovf", 32'(log_ovf), 32'd0);
`else
        pop_log();
        chk("t2_log_empty", 32'(log_empty), 32'd1);
        chk("t2_log_data", 32'(log_data), 32'h0);
        chk("t2_log_ovf", 32'(log_ovf), 32'd0);
`endif

        // Every sample inverted
        start_run();
        chk("t3_start_ffi", 32'(ffi), 32'hFF);
        run_seq(10'h3FF, 1'b0);
        chk("t3_fail_cnt", 32'(fail_cnt), 32'd10);
        chk("t3_pass_cnt", 32'(pass_cnt), 32'd0);
        chk("t3_ffi", 32'(ffi), 32'd0);
        chk("t3_pulses", 32'(pulses), 32'd10);
        chk("t3_pass", 32'(pass), 32'd0);
`ifdef MUX2_CHK_FAIL_LOG_EN
        chk("t3_log_ovf", 32'(log_ovf), 32'd1);
        chk("t3_log0", 32'(log_data), 32'h3);
        pop_log();
        chk("t3_log1", 32'(log_data), 32'h6);
        pop_log();
        chk("t3_log2", 32'(log_data), 32'h6);
        pop_log();
        chk("t3_log3", 32'(log_data), 32'h6);
        pop_log();
        chk("t3_log_empty", 32'(log_empty), 32'd1);
`else
        chk("t3_log_ovf", 32'(log_ovf), 32'd0);
        chk("t3_log_empty", 32'(log_empty), 32'd1);
`endif

        // Gapped valid with a start pulse mid-run
        start_run();
        chk("t4_start_ovf", 32'(log_ovf), 32'd0);
        run_seq(10'b0, 1'b1);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_pass_cnt", 32'(pass_cnt), 32'd10);
        chk("t4_pass", 32'(pass), 32'd1);

        // Asynchronous reset mid-run, then a clean full run
        start_run();
        pulses = 0;
        for (int i = 0; i < 5; i++) send(i, 1'b0);
        send(5, 1'b1);
        chk("t5_pre_pass_cnt", 32'(pass_cnt), 32'd5);
        chk("t5_pre_fail_cnt", 32'(fail_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_pass_cnt", 32'(pass_cnt), 32'd0);
        chk("t5_rst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("t5_rst_ffi", 32'(ffi), 32'hFF);
        chk("t5_rst_log_empty", 32'(log_empty), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();
        start_run();
        run_seq(10'b0, 1'b0);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_pass", 32'(pass), 32'd1);
        chk("t5_pass_cnt", 32'(pass_cnt), 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
